// File: rtl/weight_load_sequencer_if.sv
// weight_load_sequencer_if
//   Bundles the host load channel, the Layer 1 handshake and the weight/bias
//   memory write port of weight_load_sequencer into one interface.
//
//   Parameter
//     DATA_W  width of one weight/bias row (default RELU_NODES*LAYER_1_BIT_WIDTH)
//
//   Signals
//     loadStart, loadValid, loadData, loadReady  host load request and data beats
//     layerIdle, inputsReadyIn, inputsReadyOut   Layer 1 idle status and gated ready
//     weightWriteEnable, biasWriteEnable          memory write strobes
//     WriteAddressSelect, writeIn                 write row address and row data
//     loadDone, loadError                         completion pulse and checksum error
//     expectedChecksum                            reference checksum (only used when
//                                                 WEIGHT_LOAD_CHECKSUM_EN is defined)
//
//   Modports
//     master  host / environment side
//     slave   sequencer side

`ifndef RELU_NODES
`define RELU_NODES 10
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 16
`endif

interface weight_load_sequencer_if #(
    parameter int DATA_W = `RELU_NODES * `LAYER_1_BIT_WIDTH
);
    logic              loadStart;
    logic              loadValid;
    logic [DATA_W-1:0] loadData;
    logic              loadReady;
    logic              layerIdle;
    logic              inputsReadyIn;
    logic              inputsReadyOut;
    logic              weightWriteEnable;
    logic              biasWriteEnable;
    logic [9:0]        WriteAddressSelect;
    logic [DATA_W-1:0] writeIn;
    logic              loadDone;
    logic [15:0]       expectedChecksum;
    logic              loadError;

    modport master (
        output loadStart, loadValid, loadData, layerIdle, inputsReadyIn, expectedChecksum,
        input  loadReady, inputsReadyOut, weightWriteEnable, biasWriteEnable,
               WriteAddressSelect, writeIn, loadDone, loadError
    );

    modport slave (
        input  loadStart, loadValid, loadData, layerIdle, inputsReadyIn, expectedChecksum,
        output loadReady, inputsReadyOut, weightWriteEnable, biasWriteEnable,
               WriteAddressSelect, writeIn, loadDone, loadError
    );
endinterface

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer
//   Loads a full set of Layer 1 weight rows followed by one bias row from a
//   host valid/ready stream into the weight/bias memories. Before the first
//   beat is accepted it waits for the Layer 1 controller to drain (layerIdle),
//   and it blocks inputsReadyOut towards that controller for the whole load.
//
//   Parameters
//     NUM_ROWS  weight rows per load (one per input pixel), at most 1024
//     DATA_W    width of one weight/bias row
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    weight_load_sequencer_if.slave (host stream, Layer 1 handshake,
//            memory write port, loadDone/loadError)
//
//   Timing
//     A beat accepted on edge N produces its write strobe in the cycle after
//     edge N. The bias strobe is issued in the DONE state; loadDone (and
//     loadError) are registered in DONE and so appear one cycle after the bias
//     strobe, for exactly one cycle, while the FSM is already back in IDLE.
//
//   Configuration
//     WEIGHT_LOAD_CHECKSUM_EN  when defined, a modulo-2^16 sum of loadData[15:0]
//     over every accepted beat is compared to expectedChecksum; a mismatch sets
//     loadError, which stays set until reset or the start of the next load.
//     When undefined, loadError is tied low and expectedChecksum is ignored.

`ifndef RELU_NODES
`define RELU_NODES 10
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 16
`endif

module weight_load_sequencer #(
    parameter int NUM_ROWS = 784,
    parameter int DATA_W   = `RELU_NODES * `LAYER_1_BIT_WIDTH
) (
    input logic                    clk,
    input logic                    reset,
    weight_load_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WEIGHTS,
        BIAS,
        DONE
    } state_t;

    localparam logic [9:0] ROW_LAST = 10'(NUM_ROWS - 1);

    state_t            state;
    logic [9:0]        row_cnt;
    logic              load_ready;
    logic              accept;

    // write-port stage: registered one cycle after beat acceptance
    logic              wen_p1;
    logic              ben_p1;
    logic [9:0]        addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic              done_p1;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [15:0]       csum;
    logic              err_p1;

    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] beat);
        return acc + beat[15:0];
    endfunction
`else
    logic              unused_checksum;
    assign unused_checksum = ^bus.expectedChecksum;
`endif

    assign accept = bus.loadValid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row_cnt    <= '0;
            load_ready <= 1'b0;
            wen_p1     <= 1'b0;
            ben_p1     <= 1'b0;
            addr_p1    <= '0;
            data_p1    <= '0;
            done_p1    <= 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            csum       <= '0;
            err_p1     <= 1'b0;
`endif
        end else begin
            // strobes and the completion pulse are single-cycle by default
            wen_p1  <= 1'b0;
            ben_p1  <= 1'b0;
            done_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.loadStart) begin
                        state <= DRAIN;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                        csum   <= '0;
                        err_p1 <= 1'b0;
`endif
                    end
                end
                DRAIN: begin
                    if (bus.layerIdle) begin
                        state      <= WEIGHTS;
                        row_cnt    <= '0;
                        load_ready <= 1'b1;
                    end
                end
                WEIGHTS: begin
                    if (accept) begin
                        wen_p1  <= 1'b1;
                        addr_p1 <= row_cnt;
                        data_p1 <= bus.loadData;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                        csum    <= csum_add(csum, bus.loadData);
`endif
                        // counter parks on the last row instead of wrapping
                        if (row_cnt == ROW_LAST) begin
                            state <= BIAS;
                        end else begin
                            row_cnt <= row_cnt + 10'd1;
                        end
                    end
                end
                BIAS: begin
                    if (accept) begin
                        ben_p1     <= 1'b1;
                        addr_p1    <= '0;
                        data_p1    <= bus.loadData;
                        load_ready <= 1'b0;
                        state      <= DONE;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                        csum       <= csum_add(csum, bus.loadData);
`endif
                    end
                end
                DONE: begin
                    done_p1 <= 1'b1;
                    state   <= IDLE;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                    // csum already includes the bias beat here
                    if (csum != bus.expectedChecksum) begin
                        err_p1 <= 1'b1;
                    end
`endif
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.loadReady          = load_ready;
    assign bus.inputsReadyOut     = (state == IDLE) && bus.inputsReadyIn;
    assign bus.weightWriteEnable  = wen_p1;
    assign bus.biasWriteEnable    = ben_p1;
    assign bus.WriteAddressSelect = addr_p1;
    assign bus.writeIn            = data_p1;
    assign bus.loadDone           = done_p1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    assign bus.loadError          = err_p1;
`else
    assign bus.loadError          = 1'b0;
`endif

endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb_weight_load_sequencer
//   Scoreboard bench for weight_load_sequencer with NUM_ROWS=4, DATA_W=32.
//   The stimulus process issues loads and pushes the expected write strobes
//   and completion (with the expected cycle of each) into a queue; a monitor
//   on the falling edge pops and compares whatever the DUT presents, and
//   checks that address/data hold between strobes.

module tb_weight_load_sequencer;

    localparam int NUM_ROWS = 4;
    localparam int DATA_W   = 32;
    localparam int NBEATS   = NUM_ROWS + 1;

    bit clk   = 1'b0;
    bit reset = 1'b1;

    always #5 clk = ~clk;

    weight_load_sequencer_if #(.DATA_W(DATA_W)) bus ();

    weight_load_sequencer #(
        .NUM_ROWS(NUM_ROWS),
        .DATA_W  (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // kind: 0 = weight strobe, 1 = bias strobe, 2 = loadDone
    typedef struct {
        int                kind;
        logic [9:0]        addr;
        logic [DATA_W-1:0] data;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                fails  = 0;
    int                cyc    = 0;
    bit                rst_seen = 1'b1;
    logic [9:0]        last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;
    logic [DATA_W-1:0] beats[NBEATS];
    int                gaps[NBEATS];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            chk("rst_wen",  64'(bus.weightWriteEnable), 64'd0);
            chk("rst_ben",  64'(bus.biasWriteEnable), 64'd0);
            chk("rst_done", 64'(bus.loadDone), 64'd0);
            chk("rst_addr", 64'(bus.WriteAddressSelect), 64'd0);
            chk("rst_data", 64'(bus.writeIn), 64'd0);
            last_addr = '0;
            last_data = '0;
        end else begin
            if (bus.weightWriteEnable === 1'b1 || bus.biasWriteEnable === 1'b1) begin
                chk("strobe_exclusive", 64'(bus.weightWriteEnable & bus.biasWriteEnable), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", 64'(bus.biasWriteEnable === 1'b1 ? 1 : 0), 64'(e.kind));
                    chk("strobe_addr", 64'(bus.WriteAddressSelect), 64'(e.addr));
                    chk("strobe_data", 64'(bus.writeIn), 64'(e.data));
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_addr = bus.WriteAddressSelect;
                last_data = bus.writeIn;
            end else begin
                chk("hold_addr", 64'(bus.WriteAddressSelect), 64'(last_addr));
                chk("hold_data", 64'(bus.writeIn), 64'(last_data));
            end
            if (bus.loadDone === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", 64'd2, 64'(e.kind));
                    chk("done_error", 64'(bus.loadError), 64'(e.err));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called mid-cycle (just after a falling edge) with the DUT in IDLE.
    task automatic run_load(input int drain, input bit hold,
                            input logic [15:0] csum_in, input bit use_csum);
        logic [15:0] sum;
        logic [15:0] csum_req;
        logic        err;
        bit          r;
        bit          ok;
        int          bias_cyc;
        exp_t        e;

        sum = '0;
        for (int b = 0; b < NBEATS; b++) sum = sum + beats[b][15:0];
        if (use_csum) csum_req = csum_in;
        else csum_req = ($urandom_range(0, 1) == 1) ? sum : sum + 16'($urandom_range(1, 100));
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        err = (sum != csum_req);
`else
        err = 1'b0;
`endif
        bus.expectedChecksum = csum_req;

        r = 1'($urandom_range(0, 1));
        bus.inputsReadyIn = r;
        #1;
        chk("idle_ready_pass", 64'(bus.inputsReadyOut), 64'(r));
        chk("idle_load_ready", 64'(bus.loadReady), 64'd0);

        bus.loadStart     = 1'b1;
        bus.layerIdle     = (drain == 0);
        bus.inputsReadyIn = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.loadStart = 1'b0;

        for (int i = 0; i < drain; i++) begin
            @(negedge clk);
            chk("drain_load_ready", 64'(bus.loadReady), 64'd0);
            chk("drain_ready_out", 64'(bus.inputsReadyOut), 64'd0);
            @(posedge clk); #1;
        end
        bus.layerIdle = 1'b1;
        @(posedge clk); #1;

        for (int b = 0; b < NBEATS; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                bus.loadValid     = 1'b0;
                bus.loadData      = $urandom;
                bus.layerIdle     = 1'($urandom_range(0, 1));
                bus.inputsReadyIn = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("gap_load_ready", 64'(bus.loadReady), 64'd1);
                chk("busy_ready_out", 64'(bus.inputsReadyOut), 64'd0);
                @(posedge clk); #1;
            end
            bus.loadValid = 1'b1;
            bus.loadData  = beats[b];
            ok = 1'b0;
            for (int t = 0; t < 8; t++) begin
                @(negedge clk);
                if (bus.loadReady === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("beat_handshake", 64'(ok), 64'd1);
            e.kind = (b == NUM_ROWS) ? 1 : 0;
            e.addr = (b == NUM_ROWS) ? 10'd0 : 10'(b);
            e.data = beats[b];
            e.err  = 1'b0;
            e.cyc  = cyc + 1;
            bias_cyc = e.cyc;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        bus.loadValid = 1'b0;
        bus.loadData  = $urandom;

        e.kind = 2;
        e.addr = '0;
        e.data = '0;
        e.err  = err;
        e.cyc  = bias_cyc + 1;
        sb.push_back(e);

        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("load_complete", 64'(ok), 64'd1);
        if (!ok) sb.delete();
    endtask

    task automatic reset_mid_load();
        exp_t e;
        for (int b = 0; b < NBEATS; b++) beats[b] = $urandom;
        bus.loadStart = 1'b1;
        bus.layerIdle = 1'b1;
        @(posedge clk); #1;
        bus.loadStart = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            bus.loadValid = 1'b1;
            bus.loadData  = beats[b];
            @(negedge clk);
            chk("rstmid_load_ready", 64'(bus.loadReady), 64'd1);
            e.kind = 0;
            e.addr = 10'(b);
            e.data = beats[b];
            e.err  = 1'b0;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        // row 2 accepted; abort while the host keeps offering beats
        reset         = 1'b1;
        bus.loadData  = $urandom;
        @(posedge clk); #1;
        bus.inputsReadyIn = 1'b1;
        #1 chk("rstmid_ready_out_1", 64'(bus.inputsReadyOut), 64'd1);
        bus.inputsReadyIn = 1'b0;
        #1 chk("rstmid_ready_out_0", 64'(bus.inputsReadyOut), 64'd0);
        chk("rstmid_load_ready0", 64'(bus.loadReady), 64'd0);
        chk("rstmid_load_error", 64'(bus.loadError), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_idle_load_ready", 64'(bus.loadReady), 64'd0);
        bus.loadValid = 1'b0;
        #1 chk("rstmid_no_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        bus.loadStart        = 1'b0;
        bus.loadValid        = 1'b0;
        bus.loadData         = '0;
        bus.layerIdle        = 1'b0;
        bus.inputsReadyIn    = 1'b0;
        bus.expectedChecksum = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_load_ready", 64'(bus.loadReady), 64'd0);
        chk("reset_load_done", 64'(bus.loadDone), 64'd0);
        chk("reset_load_error", 64'(bus.loadError), 64'd0);
        chk("reset_wen", 64'(bus.weightWriteEnable), 64'd0);
        chk("reset_ben", 64'(bus.biasWriteEnable), 64'd0);
        chk("reset_addr", 64'(bus.WriteAddressSelect), 64'd0);
        chk("reset_data", 64'(bus.writeIn), 64'd0);
        bus.inputsReadyIn = 1'b1;
        #1 chk("reset_ready_out", 64'(bus.inputsReadyOut), 64'd1);
        reset = 1'b0;
        @(negedge clk); #1;

        // Directed beats 0x11..0x55 back-to-back; their 16-bit sum is 0x00FF.
        // loadStart stays high so the second load starts straight after DONE.
        for (int b = 0; b < NBEATS; b++) begin
            beats[b] = 32'(8'h11 * (b + 1));
            gaps[b]  = 0;
        end
        run_load(0, 1'b1, 16'h00FF, 1'b1);
        run_load(0, 1'b0, 16'h00FE, 1'b1);

        // long drain wait
        for (int b = 0; b < NBEATS; b++) beats[b] = $urandom;
        run_load(10, 1'b0, 16'h0000, 1'b0);

        // 3-cycle loadValid gap after row 1
        for (int b = 0; b < NBEATS; b++) begin
            beats[b] = $urandom;
            gaps[b]  = (b == 2) ? 3 : 0;
        end
        run_load(0, 1'b0, 16'h0000, 1'b0);

        reset_mid_load();

        for (int n = 0; n < 8; n++) begin
            for (int b = 0; b < NBEATS; b++) begin
                beats[b] = $urandom;
                gaps[b]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_load(int'($urandom_range(0, 4)), (n < 7) && ($urandom_range(0, 1) == 1),
                     16'h0000, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
